// File: rtl/hazard_scoreboard.sv
// Issue-control unit for the SIMD AES pipeline: per-register latency scoreboard
// that detects RAW/WAW hazards and drives stall, bubble and branch-kill controls.
module hazard_scoreboard #(
  parameter int unsigned NREGS   = 32,
  parameter int unsigned REG_W   = $clog2(NREGS),
  parameter int unsigned MAX_LAT = 4,
  parameter int unsigned LAT_W   = $clog2(MAX_LAT + 1),
  parameter int unsigned ZERO_HW = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic             id_use_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wr,
  input  logic [LAT_W-1:0] id_lat,
  input  logic             br_taken,
  input  logic             sb_clear,
  output logic             issue,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             bubble,
  output logic             kill_if,
  output logic [NREGS-1:0] busy_vec,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [LAT_W-1:0] cnt [NREGS];
  logic [LAT_W-1:0] lat_eff;
  logic             raw;
  logic             waw;
  logic             haz;
  logic             load_rd;

  // Zero latency behaves as an ALU op; oversize latencies saturate at MAX_LAT.
  always_comb begin
    lat_eff = id_lat;
    if (id_lat == '0) begin
      lat_eff = LAT_W'(1);
    end else if (id_lat > LAT_W'(MAX_LAT)) begin
      lat_eff = LAT_W'(MAX_LAT);
    end
  end

  // A count of 1 is covered by the MEM forwarding path, so only >1 blocks a read.
  always_comb begin
    raw     = (id_use_rs1 && (cnt[id_rs1] > LAT_W'(1))) ||
              (id_use_rs2 && (cnt[id_rs2] > LAT_W'(1)));
    waw     = id_wr && (cnt[id_rd] > lat_eff);
    haz     = id_valid && (raw || waw) && !sb_clear;
    issue   = id_valid && !haz && !sb_clear;
    pc_write   = !haz;
    ifid_write = !haz;
    bubble  = haz || sb_clear || !id_valid;
    kill_if = issue && br_taken;
    load_rd = issue && id_wr && !((ZERO_HW != 0) && (id_rd == '0));
  end

  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < int'(NREGS); r++) begin
      busy_vec[r] = (cnt[r] != '0);
    end
  end

  // Per-register countdown; a fresh issue to rd overrides its decrement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < int'(NREGS); r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < int'(NREGS); r++) begin
        if (sb_clear) begin
          cnt[r] <= '0;
        end else if (load_rd && (id_rd == REG_W'(r))) begin
          cnt[r] <= lat_eff;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - LAT_W'(1);
        end
      end
    end
  end

  // Saturating stall counter; survives sb_clear, only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (haz && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench: the driver queues hand-computed expectations, a
// negedge monitor pops and compares them against the scoreboard outputs.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic        id_use_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_wr;
  logic [2:0]  id_lat;
  logic        br_taken;
  logic        sb_clear;
  logic        issue;
  logic        pc_write;
  logic        ifid_write;
  logic        bubble;
  logic        kill_if;
  logic [31:0] busy_vec;
  logic [15:0] stall_cnt;

  typedef struct {
    string       name;
    logic        iss;
    logic        bub;
    logic        kill;
    logic        pcw;
    logic [31:0] busy;
    logic [15:0] stall;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_use_rs1(id_use_rs1),
    .id_rs2(id_rs2), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_wr(id_wr), .id_lat(id_lat),
    .br_taken(br_taken), .sb_clear(sb_clear),
    .issue(issue), .pc_write(pc_write), .ifid_write(ifid_write),
    .bubble(bubble), .kill_if(kill_if),
    .busy_vec(busy_vec), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] b(input int n);
    return 32'(1) << n;
  endfunction

  task automatic chk(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got=%0h expected=%0h", name, field, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle, sample mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "issue",      32'(issue),      32'(e.iss));
      chk(e.name, "bubble",     32'(bubble),     32'(e.bub));
      chk(e.name, "kill_if",    32'(kill_if),    32'(e.kill));
      chk(e.name, "pc_write",   32'(pc_write),   32'(e.pcw));
      chk(e.name, "ifid_write", 32'(ifid_write), 32'(e.pcw));
      chk(e.name, "busy_vec",   busy_vec,        e.busy);
      chk(e.name, "stall_cnt",  32'(stall_cnt),  32'(e.stall));
    end
  end

  task automatic step(input string name, input logic v,
                      input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2,
                      input logic [4:0] rd, input logic wr, input logic [2:0] lat,
                      input logic br, input logic clr,
                      input logic e_iss, input logic e_bub, input logic e_kill,
                      input logic e_pcw, input logic [31:0] e_busy,
                      input logic [15:0] e_stall);
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b1;
    id_valid = v; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
    id_rd = rd; id_wr = wr; id_lat = lat; br_taken = br; sb_clear = clr;
    e = '{name, e_iss, e_bub, e_kill, e_pcw, e_busy, e_stall};
    q.push_back(e);
  endtask

  task automatic rand_inputs();
    id_valid = 1'($urandom); id_rs1 = 5'($urandom); id_use_rs1 = 1'($urandom);
    id_rs2 = 5'($urandom); id_use_rs2 = 1'($urandom); id_rd = 5'($urandom);
    id_wr = 1'($urandom); id_lat = 3'($urandom); br_taken = 1'($urandom);
    sb_clear = 1'($urandom);
  endtask

  initial begin
    rst = 1'b0;
    rand_inputs();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      rand_inputs();
    end
    //    name        v  rs1 u  rs2 u  rd wr lat br clr  iss bub kil pcw busy             stall
    step("rst_idle",  1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 0, 1, 0, 1, 32'h0, 16'd0);
    // Load-use costs one bubble
    step("ld_issue",  1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd2, 1'b0, 1'b0, 1, 0, 0, 1, 32'h0, 16'd0);
    step("ld_use_st", 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 3'd1, 1'b0, 1'b0, 0, 1, 0, 0, b(5), 16'd0);
    step("ld_use_go", 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 3'd1, 1'b0, 1'b0, 1, 0, 0, 1, b(5), 16'd1);
    // ALU chain never stalls
    step("alu_prod",  1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 3'd1, 1'b0, 1'b0, 1, 0, 0, 1, b(6), 16'd1);
    step("alu_use1",  1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 3'd1, 1'b0, 1'b0, 1, 0, 0, 1, b(3), 16'd1);
    step("alu_use2",  1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1, 0, 0, 1, b(4), 16'd1);
    // WAW: older lat-4 write must retire before a lat-1 rewrite issues
    step("waw_old",   1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd4, 1'b0, 1'b0, 1, 0, 0, 1, 32'h0, 16'd1);
    step("waw_st1",   1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd1, 1'b0, 1'b0, 0, 1, 0, 0, b(7), 16'd1);
    step("waw_st2",   1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd1, 1'b0, 1'b0, 0, 1, 0, 0, b(7), 16'd2);
    step("waw_st3",   1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd1, 1'b0, 1'b0, 0, 1, 0, 0, b(7), 16'd3);
    step("waw_go",    1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd1, 1'b0, 1'b0, 1, 0, 0, 1, b(7), 16'd4);
    // Taken branch kills only when it issues
    step("br_free",   1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1, 0, 1, 1, b(7), 16'd4);
    step("br_prod",   1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 3'd2, 1'b0, 1'b0, 1, 0, 0, 1, 32'h0, 16'd4);
    step("br_held",   1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1, 1'b1, 1'b0, 0, 1, 0, 0, b(10), 16'd4);
    step("br_go",     1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1, 0, 1, 1, b(10), 16'd5);
    // sb_clear drops pending results and suppresses issue
    step("clr_prod",  1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd3, 1'b0, 1'b0, 1, 0, 0, 1, 32'h0, 16'd5);
    step("clr_cyc",   1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 3'd1, 1'b0, 1'b1, 0, 1, 0, 1, b(9), 16'd5);
    step("clr_dep",   1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 3'd1, 1'b0, 1'b0, 1, 0, 0, 1, 32'h0, 16'd5);
    // Self-dependency reads the pre-update count
    step("self_dep",  1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 3'd2, 1'b0, 1'b0, 1, 0, 0, 1, b(11), 16'd5);
    step("nop",       1'b0, 5'd12, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 3'd2, 1'b0, 1'b0, 0, 1, 0, 1, b(12), 16'd5);
    // Register 0 never becomes busy
    step("r0_write",  1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 3'd3, 1'b0, 1'b0, 1, 0, 0, 1, b(12), 16'd5);
    step("r0_read",   1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1, 0, 0, 1, 32'h0, 16'd5);
    // Latency 7 clamps to 4; latency 0 acts as 1
    step("lat_big",   1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 3'd7, 1'b0, 1'b0, 1, 0, 0, 1, 32'h0, 16'd5);
    step("lat_waw",   1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 3'd3, 1'b0, 1'b0, 0, 1, 0, 0, b(13), 16'd5);
    step("lat_wawgo", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 3'd3, 1'b0, 1'b0, 1, 0, 0, 1, b(13), 16'd6);
    step("lat_zero",  1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 3'd0, 1'b0, 1'b0, 1, 0, 0, 1, b(13), 16'd6);
    step("lat_use",   1'b1, 5'd14, 1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 3'd1, 1'b0, 1'b0, 0, 1, 0, 0, b(13) | b(14), 16'd6);
    step("lat_usego", 1'b1, 5'd14, 1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1, 0, 0, 1, b(13), 16'd7);
    // Reset in the middle of a stall clears everything
    step("rs_prod",   1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd15, 1'b1, 3'd4, 1'b0, 1'b0, 1, 0, 0, 1, 32'h0, 16'd7);
    step("rs_stall",  1'b1, 5'd15, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1, 1'b0, 1'b0, 0, 1, 0, 0, b(15), 16'd7);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    step("rs_after",  1'b1, 5'd15, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1, 0, 0, 1, 32'h0, 16'd0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
